code_entry: RTL

// - Front end that drives the lock FSM's MATCH/ENTER inputs. Collects CODE_LEN digits from

---
 rtl/code_entry.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/code_entry.sv
`default_nettype none
// ============================================================================
//  Module   : code_entry
//  Brief    : Combination-lock keypad front end. Collects CODE_LEN digits,
//             compares them to (or programs) a stored combination.
//  Revision : 1.0 - initial release
// ============================================================================
module code_entry #(
    parameter int                          DIGIT_W      = 4,
    parameter int                          CODE_LEN     = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                          clk,
    input  logic                          RESETN,
    input  logic                          KEY_N,
    input  logic                          CLR_N,
    input  logic [DIGIT_W-1:0]            SW,
    input  logic                          SET,
    input  logic                          UNLOCKED,
    output logic                          ENTER,
    output logic                          MATCH,
    output logic                          SAVED,
    output logic [$clog2(CODE_LEN+1)-1:0] COUNT
);

    localparam int                  c_CODE_W  = DIGIT_W * CODE_LEN;
    localparam int                  c_CNT_W   = $clog2(CODE_LEN + 1);
    localparam logic [c_CNT_W-1:0]  c_LAST    = c_CNT_W'(CODE_LEN - 1);
    localparam logic [0:0]          c_COLLECT = 1'b0;
    localparam logic [0:0]          c_ISSUE   = 1'b1;

    // [1:0] synchronise, [2] remembers the previous synchronised level.
    logic [2:0]          r_key_sync;
    logic [2:0]          r_clr_sync;
    logic                w_key_evt;
    logic                w_clr_evt;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_CODE_W-1:0] r_buf;
    logic [c_CODE_W-1:0] r_stored;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_enter;
    logic                r_saved;
    logic                r_match;

    logic [c_CODE_W-1:0] w_shifted;
    logic                w_program;
    logic [c_CODE_W-1:0] w_buf_nxt;
    logic [c_CODE_W-1:0] w_stored_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_enter_nxt;
    logic                w_saved_nxt;
    logic                w_match_nxt;

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            r_key_sync <= 3'b111;
            r_clr_sync <= 3'b111;
        end else begin
            r_key_sync <= {r_key_sync[1:0], KEY_N};
            r_clr_sync <= {r_clr_sync[1:0], CLR_N};
        end
    end

    assign w_key_evt = r_key_sync[2] & ~r_key_sync[1];
    assign w_clr_evt = r_clr_sync[2] & ~r_clr_sync[1];
    assign w_shifted = {r_buf[c_CODE_W-DIGIT_W-1:0], SW};
    assign w_program = SET & UNLOCKED;

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= c_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_COLLECT: begin
                if (w_key_evt && !w_clr_evt && (r_count == c_LAST)) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE:   w_state_nxt = c_COLLECT;
            default:   w_state_nxt = c_COLLECT;
        endcase
    end

    // Strobes are decided on the edge that captures the final digit so they
    // are registered yet coincide with the single ISSUE cycle.
    always_comb begin
        w_buf_nxt    = r_buf;
        w_stored_nxt = r_stored;
        w_cnt_nxt    = r_count;
        w_enter_nxt  = 1'b0;
        w_saved_nxt  = 1'b0;
        w_match_nxt  = r_match;
        case (r_state)
            c_COLLECT: begin
                if (w_clr_evt) begin
                    w_buf_nxt = '0;
                    w_cnt_nxt = '0;
                end else if (w_key_evt) begin
                    w_buf_nxt = w_shifted;
                    w_cnt_nxt = r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        if (w_program) begin
                            w_stored_nxt = w_shifted;
                            w_saved_nxt  = 1'b1;
                        end else begin
                            w_enter_nxt = 1'b1;
                            w_match_nxt = (w_shifted == r_stored);
                        end
                    end
                end
            end
            c_ISSUE: begin
                w_buf_nxt = '0;
                w_cnt_nxt = '0;
            end
            default: begin
                w_buf_nxt = '0;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            r_buf    <= '0;
            r_stored <= DEFAULT_CODE;
            r_count  <= '0;
            r_enter  <= 1'b0;
            r_saved  <= 1'b0;
            r_match  <= 1'b0;
        end else begin
            r_buf    <= w_buf_nxt;
            r_stored <= w_stored_nxt;
            r_count  <= w_cnt_nxt;
            r_enter  <= w_enter_nxt;
            r_saved  <= w_saved_nxt;
            r_match  <= w_match_nxt;
        end
    end

    assign ENTER = r_enter;
    assign SAVED = r_saved;
    assign MATCH = r_match;
    assign COUNT = r_count;

endmodule
`default_nettype wire
